// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU OUT-instruction path.
// Optional feature macro: OUT_PORT_PARITY_EN. When it is defined, every
// queued entry carries an even-parity bit alongside its data.
package cpu_io_pkg;

  localparam int OUT_DATA_W     = 8;
  localparam int OUT_FIFO_DEPTH = 4;

`ifdef OUT_PORT_PARITY_EN
  localparam int OUT_PAR_W = 1;

  typedef struct packed {
    logic                  parity;
    logic [OUT_DATA_W-1:0] data;
  } out_entry_t;
`else
  localparam int OUT_PAR_W = 0;

  typedef struct packed {
    logic [OUT_DATA_W-1:0] data;
  } out_entry_t;
`endif

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [OUT_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. Each pointer carries one extra MSB, so that
// full and empty can be told apart even when the index bits are equal.
// The read port is not fall-through: rd_data is the entry at the registered
// read pointer, and it is forced to zero while the FIFO is empty. Because of
// this, rd_data comes out of reset at zero although the storage itself is
// never cleared.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is silently dropped.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer registers. Each one wraps naturally through its extra MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Entry storage. It is left unreset; empty gates whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/out_port_buffer.sv
// OUT-instruction output buffer.
// Every retiring OUT write is latched onto the architectural port O_Port.
// The same write is also queued for an external consumer, which drains the
// queue through a valid/ready handshake. While the queue is full, a
// retiring OUT holds the pipeline through stall.
// Optional feature macro: OUT_PORT_PARITY_EN. When it is defined, the block
// gains the ext_parity output, and every entry stores even parity of its
// data.
module out_port_buffer
  import cpu_io_pkg::*;
#(
  parameter  int DATA_W = OUT_DATA_W,
  parameter  int DEPTH  = OUT_FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic              stall,
  output logic [DATA_W-1:0] O_Port,
  output logic              ext_valid,
  output logic [DATA_W-1:0] ext_data,
  input  logic              ext_ready,
`ifdef OUT_PORT_PARITY_EN
  output logic              ext_parity,
`endif
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam int ENTRY_W = DATA_W + OUT_PAR_W;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // A pop in the same cycle does not free the slot in time for the push.
  // The refused write is retried on the next cycle, because the CPU holds
  // it until stall drops.
  assign push  = out_we & ~full;
  assign pop   = ext_valid & ext_ready;
  assign stall = out_we & full;

`ifdef OUT_PORT_PARITY_EN
  assign wr_entry   = {^out_data, out_data};
  assign ext_parity = rd_entry[DATA_W];
`else
  assign wr_entry   = out_data;
`endif

  assign ext_data  = rd_entry[DATA_W-1:0];
  assign ext_valid = ~empty;

  // Architectural port: only accepted writes update it; draining never does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      O_Port <= '0;
    end else if (push) begin
      O_Port <= out_data;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer (default build; when
// OUT_PORT_PARITY_EN is defined, the parity port is checked as well).
module tb_out_port_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              out_we;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic [DATA_W-1:0] O_Port;
  logic              ext_valid;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ready;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
`ifdef OUT_PORT_PARITY_EN
  logic              ext_parity;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_oport;
  logic [DATA_W-1:0] exp_val;

  always #5 clk = ~clk;

  out_port_buffer dut (
    .clk       (clk),
    .rstn      (rstn),
    .out_we    (out_we),
    .out_data  (out_data),
    .stall     (stall),
    .O_Port    (O_Port),
    .ext_valid (ext_valid),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
`ifdef OUT_PORT_PARITY_EN
    .ext_parity(ext_parity),
`endif
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks the FIFO head against the scoreboard while ext_ready is high.
  // Only call it when the model expects a non-empty queue.
  task automatic test_pop_head(input string name);
    tests_run++;
    if (ext_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s valid: got %b expected 1", name, ext_valid);
    end else if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: got unexpected data %h expected nothing queued", name, ext_data);
    end else begin
      exp_val = sb_q.pop_front();
      if (ext_data !== exp_val) begin
        tests_failed++;
        $display("FAIL %s data: got %h expected %h", name, ext_data, exp_val);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; out_we = 1'b0; out_data = '0; ext_ready = 1'b0;
    sb_q.delete();
    exp_oport = '0;
    repeat (2) tick();
    tests_run++;
    if ({O_Port, ext_valid, count, empty, full, stall, ext_data} !==
        {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset: got oport=%h valid=%b cnt=%0d empty=%b full=%b stall=%b data=%h expected 00/0/0/1/0/0/00",
               O_Port, ext_valid, count, empty, full, stall, ext_data);
    end
`ifdef OUT_PORT_PARITY_EN
    tests_run++;
    if (ext_parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset parity: got %b expected 0", ext_parity);
    end
`endif
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_we = 1'b1; out_data = 8'h55;
    #1;
    tests_run++;
    if (ext_valid !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL single pre: got valid=%b stall=%b expected 0/0", ext_valid, stall);
    end
    sb_q.push_back(8'h55); exp_oport = 8'h55;
    tick();
    out_we = 1'b0;
    #1;
    tests_run++;
    if (O_Port !== exp_oport || count !== 3'd1 || ext_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single push: got oport=%h cnt=%0d valid=%b expected %h/1/1", O_Port, count, ext_valid, exp_oport);
    end
    ext_ready = 1'b1;
    #1;
    test_pop_head("single_pop");
    tick();
    ext_ready = 1'b0;
    #1;
    tests_run++;
    if (empty !== 1'b1 || O_Port !== exp_oport) begin
      tests_failed++;
      $display("FAIL single drained: got empty=%b oport=%h expected 1/%h", empty, O_Port, exp_oport);
    end
  endtask

  task automatic test_full_stall();
    for (int i = 1; i <= 4; i++) begin
      out_we = 1'b1; out_data = 8'(i * 8'h11);
      sb_q.push_back(out_data); exp_oport = out_data;
      tick();
    end
    out_we = 1'b1; out_data = 8'h55;
    #1;
    tests_run++;
    if (full !== 1'b1 || count !== 3'd4 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL full: got full=%b cnt=%0d stall=%b expected 1/4/1", full, count, stall);
    end
    tick();
    tests_run++;
    if (O_Port !== 8'h44 || count !== 3'd4) begin
      tests_failed++;
      $display("FAIL stalled write: got oport=%h cnt=%0d expected 44/4", O_Port, count);
    end
    ext_ready = 1'b1;
    #1;
    test_pop_head("full_pulse_pop");
    tick();
    ext_ready = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0 || count !== 3'd3) begin
      tests_failed++;
      $display("FAIL stall release: got stall=%b cnt=%0d expected 0/3", stall, count);
    end
    sb_q.push_back(8'h55); exp_oport = 8'h55;
    tick();
    out_we = 1'b0;
    #1;
    tests_run++;
    if (O_Port !== 8'h55 || count !== 3'd4) begin
      tests_failed++;
      $display("FAIL retry accept: got oport=%h cnt=%0d expected 55/4", O_Port, count);
    end
    for (int k = 0; k < 4; k++) begin
      ext_ready = 1'b1;
      #1;
      test_pop_head("full_drain");
      tick();
    end
    ext_ready = 1'b0;
    #1;
    tests_run++;
    if (empty !== 1'b1 || O_Port !== 8'h55 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL full drained: got empty=%b oport=%h left=%0d expected 1/55/0", empty, O_Port, sb_q.size());
    end
  endtask

  task automatic test_stream();
    ext_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_we = 1'b1; out_data = 8'hA0 + 8'(i);
      #1;
      tests_run++;
      if (stall !== 1'b0 || count > 3'd1) begin
        tests_failed++;
        $display("FAIL stream occupancy: got stall=%b cnt=%0d expected 0/<=1", stall, count);
      end
      if (sb_q.size() > 0) test_pop_head("stream");
      sb_q.push_back(out_data); exp_oport = out_data;
      tick();
    end
    out_we = 1'b0;
    #1;
    test_pop_head("stream_last");
    tick();
    ext_ready = 1'b0;
    #1;
    tests_run++;
    if (empty !== 1'b1 || O_Port !== 8'hAF || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream end: got empty=%b oport=%h left=%0d expected 1/af/0", empty, O_Port, sb_q.size());
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      out_we = 1'b1; out_data = 8'hB0 + 8'(i);
      sb_q.push_back(out_data); exp_oport = out_data;
      tick();
    end
    out_we = 1'b1; out_data = 8'hB4; ext_ready = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul stall: got %b expected 1", stall);
    end
    test_pop_head("simul_pop");
    tick();
    ext_ready = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd3 || stall !== 1'b0 || O_Port !== 8'hB3) begin
      tests_failed++;
      $display("FAIL simul after pop: got cnt=%0d stall=%b oport=%h expected 3/0/b3", count, stall, O_Port);
    end
    sb_q.push_back(8'hB4); exp_oport = 8'hB4;
    tick();
    out_we = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd4 || O_Port !== exp_oport) begin
      tests_failed++;
      $display("FAIL simul refill: got cnt=%0d oport=%h expected 4/%h", count, O_Port, exp_oport);
    end
    for (int k = 0; k < 4; k++) begin
      ext_ready = 1'b1;
      #1;
      test_pop_head("simul_drain");
      tick();
    end
    ext_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      out_we = 1'b1; out_data = 8'(i * 8'h11);
      sb_q.push_back(out_data); exp_oport = out_data;
      tick();
    end
    out_we = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd3 || O_Port !== 8'h33) begin
      tests_failed++;
      $display("FAIL pre-reset: got cnt=%0d oport=%h expected 3/33", count, O_Port);
    end
    out_we = 1'b1; out_data = 8'h99;
    #1;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({O_Port, ext_valid, count, stall, empty} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL async reset: got oport=%h valid=%b cnt=%0d stall=%b empty=%b expected 00/0/0/0/1",
               O_Port, ext_valid, count, stall, empty);
    end
    out_we = 1'b0;
    sb_q.delete(); exp_oport = '0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

`ifdef OUT_PORT_PARITY_EN
  task automatic test_parity();
    logic [DATA_W-1:0] pv [2];
    logic              pe [2];
    pv[0] = 8'h07; pe[0] = 1'b1;
    pv[1] = 8'h03; pe[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      out_we = 1'b1; out_data = pv[i];
      sb_q.push_back(pv[i]);
      tick();
      out_we = 1'b0;
      #1;
      tests_run++;
      if (ext_parity !== pe[i]) begin
        tests_failed++;
        $display("FAIL parity %h: got %b expected %b", pv[i], ext_parity, pe[i]);
      end
      ext_ready = 1'b1;
      #1;
      test_pop_head("parity_pop");
      tick();
      ext_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_stream();
    test_full_simul();
    test_async_reset();
`ifdef OUT_PORT_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/out_port_buffer.md
Name: out_port_buffer

Overview:
- Downstream of the CPU's OUT-instruction path: captures every retiring OUT write (register value) and drives it onto the architectural output port `O_Port`.
- Also queues each write in a small FIFO, so an external consumer (e.g. a UART/LED peripheral) can drain values with a valid/ready handshake without losing back-to-back OUTs.
- Back-pressures the pipeline through `stall` when the queue is full.

Parameters:
- DATA_W, 8, width of port data and FIFO entries.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- out_we  in  1  OUT instruction retiring this cycle (from writeback stage).
- out_data  in  DATA_W  register value written by OUT.
- stall  out  1  pipeline hold request: high when out_we and FIFO full.
- O_Port  out  DATA_W  last accepted OUT value (architectural output port).
- ext_valid  out  1  FIFO head valid for external consumer.
- ext_data  out  DATA_W  FIFO head data.
- ext_ready  in  1  consumer accepts head this cycle.
- count  out  PTR_W+1  current FIFO occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (`clk`, `rstn`).
- Reset values:
  - O_Port = 0, ext_valid = 0, count = 0, empty = 1, full = 0.
  - Read/write pointers = 0.
  - ext_data = 0 (FIFO storage need not be cleared).
  - stall = 0 (combinational from out_we & full).
- Push:
  - push = out_we & ~full.
  - On push, O_Port <= out_data at the same edge, i.e. visible 1 cycle after out_we.
  - The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop:
  - pop = ext_valid & ext_ready.
  - rd_ptr increments modulo DEPTH.
  - ext_data is the registered-pointer read of the head (not fall-through): the first value appears with ext_valid high 1 cycle after the push into an empty FIFO.
- stall:
  - stall = out_we & full, purely combinational.
  - The write is not accepted, and O_Port and FIFO are unchanged.
  - The CPU holds out_we/out_data stable until stall drops.
- Simultaneous push & pop:
  - Not full and not empty: both occur, count unchanged.
  - Full: the push is refused (stall high) even if pop occurs the same cycle; it is accepted the next cycle.
  - Empty: no pop possible (ext_valid=0); the push proceeds.
- ext_valid = ~empty.
- ext_data is held stable while ext_valid & ~ext_ready. Consumers may hold ext_ready high continuously.
- Pointer wrap: pointers carry one extra MSB; full/empty derive from pointer compare, and count = wr_ptr - rd_ptr.
- Reset mid-operation: asynchronous clear of pointers, count, and O_Port. In-flight queued data is discarded, and stall drops immediately.
- O_Port is independent of the consumer: draining never changes O_Port.

Optional Feature:
- Macro: OUT_PORT_PARITY_EN.
- Defined:
  - Adds output ext_parity (1 bit) = even parity of ext_data, stored per entry at push time (FIFO width DATA_W+1).
  - ext_parity resets to 0.
- Undefined: port and storage bit absent; FIFO width = DATA_W.

Decomposition:
- Shared package cpu_io_pkg:
  - OUT_DATA_W = 8, OUT_FIFO_DEPTH = 4.
  - Typedef out_entry_t (data + optional parity).
- Sub-module sync_fifo:
  - Generic DEPTH × width register array, wr/rd pointers, full/empty/count.
  - Instantiated once; out_port_buffer adds O_Port register, stall logic, parity.

Test Plan:
- Reset, then a single out_we with out_data=0x55 → next edge O_Port=0x55, ext_valid=1, ext_data=0x55, count=1; ext_ready=1 one cycle → empty=1, O_Port stays 0x55.
- ext_ready=0, out_we for 4 consecutive cycles with 0x11,0x22,0x33,0x44 → full=1, count=4. Fifth out_we with 0x55 → stall=1 and O_Port stays 0x44. Pulse ext_ready → stall drops next cycle, 0x55 accepted, drain order 11,22,33,44,55.
- ext_ready held 1 while streaming 0xA0..0xAF, one per cycle → stall never asserts, count ≤1, ext_data sequence matches input order across pointer wrap.
- Full FIFO with out_we and ext_ready both high in the same cycle → pop occurs, push refused (stall=1), count goes 4→3, then push accepted next cycle → count back to 4.
- With count=3 and O_Port=0x33, assert rstn=0 asynchronously mid-cycle → O_Port=0, ext_valid=0, count=0, stall=0 immediately, before the next edge.
- OUT_PORT_PARITY_EN defined: push 0x07 → ext_parity=1; push 0x03 → ext_parity=0.
